cla_serial_ctrl: RTL

CLA_SERIAL_CTRL -- requirements
Module: cla_serial_ctrl

---
 rtl/cla_serial_pkg.sv | 12 +
 rtl/carry_lookahead_adder.sv | 26 ++
 rtl/cla_serial_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cla_serial_pkg.sv
// Shared types for the serial carry-lookahead controller: FSM states and slice width.
package cla_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// 4-bit carry-lookahead adder slice; purely combinational, all carries from generate/propagate terms.
module carry_lookahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

endmodule

// File: rtl/cla_serial_ctrl.sv
// WIDTH-bit adder sequencing one shared 4-bit CLA slice LSB-nibble first; result after WIDTH/4 ADD cycles,
// held in DONE until out_ready. Optional signed-overflow port ovf under `CLA_SERIAL_OVF_EN.
module cla_serial_ctrl
  import cla_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NIB  = WIDTH / NIBBLE_W;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    sum_q;
  logic                carry;
  logic [IDXW-1:0]     idx;
  logic                last;
  logic [NIBBLE_W-1:0] sl_a;
  logic [NIBBLE_W-1:0] sl_b;
  logic [NIBBLE_W-1:0] sl_sum;
  logic                sl_cout;

  assign last = (idx == IDXW'(NIB - 1));
  assign sl_a = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign sl_b = b_q[idx*NIBBLE_W +: NIBBLE_W];

  carry_lookahead_adder u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD;
      end
      ADD: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The carry register doubles as the final carry-out once ADD completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        ADD: begin
          sum_q[idx*NIBBLE_W +: NIBBLE_W] <= sl_sum;
          carry <= sl_cout;
          idx   <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = carry;

`ifdef CLA_SERIAL_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state == ADD && last) begin
      ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
